// File: rtl/pwm_ramp_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel duty ramp.
// Waypoint offsets and per-stage DDA step/remainder constants live here.
package pwm_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int wp_off(
        input int c,
        input int p,
        input int stages,
        input int width
    );
        return (c * (stages + 1) + p) * width;
    endfunction

    function automatic int dda_q(
        input int a,
        input int b,
        input int n
    );
        return (b - a) / n;
    endfunction

    function automatic int dda_r(
        input int a,
        input int b,
        input int n
    );
        int d;
        d = b - a;
        if (d < 0) d = -d;
        return d % n;
    endfunction

endpackage

// File: rtl/pwm_ramp_dda.sv
// One channel's duty stepper: integer DDA between waypoints, with a snap
// load that forces the duty word to a table point and clears the remainder.
module pwm_ramp_dda
    import pwm_ramp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STAGES = 6,
    parameter int N = 20000,
    parameter logic [(STAGES+1)*WIDTH-1:0] PTS = '0,
    parameter int SW = 3,
    parameter int PW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [PW-1:0]    load_pt_i,
    input  logic             upd_i,
    input  logic [SW-1:0]    stage_i,
    output logic [WIDTH-1:0] duty_o
);

    localparam int AW = $clog2(N) + 1;
    localparam int DW = WIDTH + 2;
    localparam logic [WIDTH-1:0] P0 = PTS[WIDTH-1:0];

    logic [WIDTH-1:0]     pt_tab  [STAGES+1];
    logic signed [DW-1:0] q_tab   [STAGES];
    logic [AW-1:0]        r_tab   [STAGES];
    logic                 neg_tab [STAGES];

    for (genvar p = 0; p <= STAGES; p++) begin : g_pt
        assign pt_tab[p] = PTS[wp_off(0, p, STAGES, WIDTH) +: WIDTH];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_seg
        localparam int A = int'(PTS[wp_off(0, s, STAGES, WIDTH) +: WIDTH]);
        localparam int B = int'(PTS[wp_off(0, s + 1, STAGES, WIDTH) +: WIDTH]);
        assign q_tab[s]   = DW'(dda_q(A, B, N));
        assign r_tab[s]   = AW'(dda_r(A, B, N));
        assign neg_tab[s] = (B < A);
    end

    logic [WIDTH-1:0]     duty_q, duty_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic signed [DW-1:0] step;
    logic [AW-1:0]        acc_sum;

    always_comb begin
        duty_d  = duty_q;
        acc_d   = acc_q;
        step    = $signed({2'b00, duty_q}) + q_tab[stage_i];
        acc_sum = acc_q + r_tab[stage_i];
        if (load_i) begin
            duty_d = pt_tab[load_pt_i];
            acc_d  = '0;
        end else if (upd_i) begin
            // Remainder overflow carries one extra LSB toward the target.
            if (acc_sum >= AW'(N)) begin
                acc_d = acc_sum - AW'(N);
                step  = neg_tab[stage_i] ? step - DW'(1) : step + DW'(1);
            end else begin
                acc_d = acc_sum;
            end
            duty_d = step[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= P0;
            acc_q  <= '0;
        end else begin
            duty_q <= duty_d;
            acc_q  <= acc_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/pwm_ramp_multi.sv
// Multi-channel piecewise-linear duty ramp: shared stage/update controller
// driving one DDA per channel. Define PWM_RAMP_PWM_OUT_EN for pwm_out.
module pwm_ramp_multi
    import pwm_ramp_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH = 8,
    parameter int STAGES = 6,
    parameter int STAGE_CYCLES = 2000000,
    parameter int UPDATE_DIV = 100,
    parameter logic [CHANNELS*(STAGES+1)*WIDTH-1:0] WAYPOINTS = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      loop,
    input  logic                      restart,
    output logic [CHANNELS*WIDTH-1:0] duty,
    output logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] stage,
    output logic                      stage_pulse,
    output logic                      done
`ifdef PWM_RAMP_PWM_OUT_EN
    ,
    output logic [CHANNELS-1:0]       pwm_out
`endif
);

    localparam int N    = STAGE_CYCLES / UPDATE_DIV;
    localparam int SW   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int PW   = $clog2(STAGES + 1);
    localparam int DIVW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int CYCW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;

    if (STAGE_CYCLES % UPDATE_DIV != 0) begin : g_bad_div
        $error("STAGE_CYCLES must be a multiple of UPDATE_DIV");
    end

    state_e          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [CYCW-1:0] cyc_q, cyc_d;
    logic            pulse_q, pulse_d;
    logic            done_q, done_d;
    logic            load;
    logic [PW-1:0]   load_pt;
    logic            upd;
    logic            div_last;
    logic            cyc_last;

    assign div_last = (div_q == DIVW'(UPDATE_DIV - 1));
    assign cyc_last = (cyc_q == CYCW'(STAGE_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        div_d   = div_q;
        cyc_d   = cyc_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        load_pt = '0;
        upd     = 1'b0;
        if (restart) begin
            state_d = RUN;
            stage_d = '0;
            div_d   = '0;
            cyc_d   = '0;
            load    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) state_d = RUN;
                end
                RUN: begin
                    if (en) begin
                        div_d = div_last ? '0 : div_q + 1'b1;
                        cyc_d = cyc_last ? '0 : cyc_q + 1'b1;
                        upd   = div_last;
                        if (cyc_last) begin
                            pulse_d = 1'b1;
                            load    = 1'b1;
                            if (stage_q == SW'(STAGES - 1)) begin
                                if (loop) begin
                                    stage_d = '0;
                                end else begin
                                    state_d = DONE;
                                    load_pt = PW'(STAGES);
                                end
                            end else begin
                                stage_d = stage_q + 1'b1;
                                load_pt = PW'(stage_q) + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            div_q   <= '0;
            cyc_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            div_q   <= div_d;
            cyc_q   <= cyc_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    logic [WIDTH-1:0] duty_w [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pwm_ramp_dda #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .N     (N),
            .PTS   (WAYPOINTS[wp_off(c, 0, STAGES, WIDTH) +: (STAGES+1)*WIDTH]),
            .SW    (SW),
            .PW    (PW)
        ) u_dda (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (load),
            .load_pt_i(load_pt),
            .upd_i    (upd),
            .stage_i  (stage_q),
            .duty_o   (duty_w[c])
        );
        assign duty[c*WIDTH +: WIDTH] = duty_w[c];
    end

    assign stage       = stage_q;
    assign stage_pulse = pulse_q;
    assign done        = done_q;

`ifdef PWM_RAMP_PWM_OUT_EN
    logic [WIDTH-1:0]    pwm_cnt_q;
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pwm_d[c] = (pwm_cnt_q < duty_w[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            pwm_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_multi.sv
// Directed bench for pwm_ramp_multi: 2 channels, 2 stages, N=3.
module tb_pwm_ramp_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        loop;
    logic        restart;
    logic [15:0] duty;
    logic [0:0]  stage;
    logic        stage_pulse;
    logic        done;

    int n_run  = 0;
    int n_fail = 0;

    int E0 [6] = '{0, 3, 6, 10, 8, 6};
    int E1 [6] = '{255, 255, 255, 255, 170, 85};

    always #5 clk = ~clk;

`ifdef PWM_RAMP_PWM_OUT_EN
    logic [1:0]  pwm_out;
    logic [15:0] duty2;
    logic [0:0]  stage2;
    logic        pulse2;
    logic        done2;
    logic [1:0]  pwm_out2;
`endif

    pwm_ramp_multi #(
        .CHANNELS    (2),
        .WIDTH       (8),
        .STAGES      (2),
        .STAGE_CYCLES(12),
        .UPDATE_DIV  (4),
        .WAYPOINTS   (48'h00FFFF040A00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .loop       (loop),
        .restart    (restart),
        .duty       (duty),
        .stage      (stage),
        .stage_pulse(stage_pulse),
        .done       (done)
`ifdef PWM_RAMP_PWM_OUT_EN
        ,
        .pwm_out    (pwm_out)
`endif
    );

`ifdef PWM_RAMP_PWM_OUT_EN
    pwm_ramp_multi #(
        .CHANNELS    (2),
        .WIDTH       (8),
        .STAGES      (2),
        .STAGE_CYCLES(12),
        .UPDATE_DIV  (4),
        .WAYPOINTS   (48'h000000404040)
    ) dut_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (1'b0),
        .loop       (1'b0),
        .restart    (1'b0),
        .duty       (duty2),
        .stage      (stage2),
        .stage_pulse(pulse2),
        .done       (done2),
        .pwm_out    (pwm_out2)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int e0, input int e1,
                             input int st);
        check({tag, " d0"}, {24'd0, duty[7:0]}, e0);
        check({tag, " d1"}, {24'd0, duty[15:8]}, e1);
        check({tag, " stage"}, {31'd0, stage}, st);
    endtask

    // k counts rising edges after en goes high from IDLE
    task automatic run_seq(input bit lp, input int nk);
        int jj, u, e0, e1, st, pl, dn;
        for (int k = 1; k <= nk; k++) begin
            tick();
            if (!lp && k >= 25) begin
                e0 = 4;
                e1 = 0;
                st = 1;
                pl = (k == 25) ? 1 : 0;
                dn = (k >= 26) ? 1 : 0;
            end else begin
                jj = (k - 1) % 24;
                u  = jj / 4;
                e0 = E0[u];
                e1 = E1[u];
                st = (jj >= 12) ? 1 : 0;
                pl = ((jj == 12) || (jj == 0 && k > 1)) ? 1 : 0;
                dn = 0;
            end
            check_out($sformatf("seq%0d k%0d", lp, k), e0, e1, st);
            check($sformatf("seq%0d k%0d pulse", lp, k),
                  {31'd0, stage_pulse}, pl);
            check($sformatf("seq%0d k%0d done", lp, k), {31'd0, done}, dn);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        loop    = 1'b0;
        restart = 1'b0;
        tick(2);
        check_out("reset", 0, 255, 0);
        check("reset pulse", {31'd0, stage_pulse}, 0);
        check("reset done", {31'd0, done}, 0);
        rst_n = 1'b1;
        tick();
        check_out("idle", 0, 255, 0);

        en = 1'b1;
        run_seq(1'b0, 30);
        tick(3);
        check("done hold", {31'd0, done}, 1);
        check_out("done hold", 4, 0, 1);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_out("rst_done", 0, 255, 0);
        check("rst_done done", {31'd0, done}, 0);
        check("rst_done pulse", {31'd0, stage_pulse}, 0);
        tick(3);
        check("rst_done pre", {24'd0, duty[7:0]}, 0);
        tick();
        check("rst_done upd1", {24'd0, duty[7:0]}, 3);

        en = 1'b0;
        tick(5);
        check("pause hold", {24'd0, duty[7:0]}, 3);
        en = 1'b1;
        tick(3);
        check("pause pre", {24'd0, duty[7:0]}, 3);
        tick();
        check("pause upd2", {24'd0, duty[7:0]}, 6);

        tick(4);
        check_out("bnd1", 10, 255, 1);
        check("bnd1 pulse", {31'd0, stage_pulse}, 1);
        tick(2);
        check("bnd1 after pulse", {31'd0, stage_pulse}, 0);
        check_out("mid s1", 10, 255, 1);

        en      = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_out("rst_en0", 0, 255, 0);
        check("rst_en0 done", {31'd0, done}, 0);
        tick(3);
        check("rst_en0 hold", {24'd0, duty[7:0]}, 0);
        en = 1'b1;
        tick(4);
        check("rst_en0 upd1", {24'd0, duty[7:0]}, 3);

        tick(8);
        check_out("pre_ar bnd", 10, 255, 1);
        tick(4);
        check_out("pre_ar", 8, 170, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("async rst", 0, 255, 0);
        check("async rst pulse", {31'd0, stage_pulse}, 0);
        check("async rst done", {31'd0, done}, 0);
        tick();
        rst_n = 1'b1;
        tick(4);
        check("post_ar pre", {24'd0, duty[7:0]}, 0);
        tick();
        check("post_ar upd1", {24'd0, duty[7:0]}, 3);

        rst_n = 1'b0;
        en    = 1'b0;
        loop  = 1'b1;
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        run_seq(1'b1, 50);

`ifdef PWM_RAMP_PWM_OUT_EN
        begin
            int highs;
            highs = 0;
            tick(3);
            for (int i = 0; i < 256; i++) begin
                if (pwm_out2[0]) highs++;
                tick();
            end
            check("pwm high count", highs, 64);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_multi.md
# pwm_ramp_multi

Multi-channel piecewise-linear duty-cycle ramp generator for LED dimming and colour sequencing. Each channel walks a compile-time waypoint table over a fixed number of equal-length stages. Integer DDA stepping lands exactly on every waypoint, with no drift and no real arithmetic. It feeds per-channel duty words to PWM drivers and can optionally embed the PWM comparator itself.

## Interface
- CHANNELS, 3: number of independent duty channels.
- WIDTH, 8: duty word width in bits.
- STAGES, 6: ramp segments; the table holds STAGES+1 points per channel.
- STAGE_CYCLES, 2000000: clock cycles per stage.
- UPDATE_DIV, 100: clock cycles between duty updates. STAGE_CYCLES must be a multiple of UPDATE_DIV; violation is an elaboration error.
- WAYPOINTS, 0: flattened unsigned table, [CHANNELS*(STAGES+1)*WIDTH-1:0]. Channel c, point p is at bits [(c*(STAGES+1)+p)*WIDTH +: WIDTH].
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low pauses all counters and holds the duty words.
- loop  in  1  1 = wrap to stage 0 after the last stage; 0 = stop in DONE.
- restart  in  1  single-cycle pulse; restarts the sequence from stage 0.
- duty  out  CHANNELS x WIDTH  current duty word per channel (registered).
- stage  out  $clog2(STAGES)  index of the current stage.
- stage_pulse  out  1  one-cycle pulse on every stage boundary.
- done  out  1  high while in DONE.

## Operation
- N = STAGE_CYCLES/UPDATE_DIV is the number of updates per stage.
- Per channel and stage s, these are elaboration-time constants:
  - delta = WP[s+1] − WP[s], signed, WIDTH+1 bits.
  - q = delta/N, truncated toward zero.
  - r = |delta| mod N.
- Each update, per channel: duty += q; acc += r; if acc ≥ N then duty += sign(delta) and acc −= N. acc is unsigned, $clog2(N)+1 bits.
- FSM:
  - IDLE: entered on reset; duty = WP[0]; moves to RUN on the first cycle with en=1.
  - RUN: div_cnt counts 0..UPDATE_DIV−1 and cyc_cnt counts 0..STAGE_CYCLES−1, both only while en=1. An update fires when div_cnt = UPDATE_DIV−1.
  - Stage boundary when cyc_cnt = STAGE_CYCLES−1: duty snaps to WP[s+1], acc clears, stage_pulse=1, stage increments.
  - Last stage boundary: with loop=1, go to stage 0 and duty = WP[0]. A jump from WP[STAGES] to WP[0] is legal. With loop=0, go to DONE.
  - DONE: duty holds WP[STAGES]; done=1; leaves only on restart.
- restart, from any state, has priority over everything except reset: next cycle is RUN, stage 0, counters and acc cleared, duty = WP[0]. This applies even when en=0.
- Simultaneous update and stage boundary: the snap wins; the values agree by construction.
- Reset mid-operation: all state returns immediately to reset values.

## Timing
- Reset values: duty = WP[0] per channel, stage = 0, stage_pulse = 0, done = 0, FSM = IDLE, all counters 0.
- The first update appears on duty UPDATE_DIV cycles after the first en=1 cycle in RUN.
- stage changes in the same cycle stage_pulse is high.
- done rises in the cycle after the final boundary.
- en deassertion takes effect in the same cycle: counters hold with no lost or extra update.

## Configuration
- PWM_RAMP_PWM_OUT_EN defined:
  - Adds output pwm_out [CHANNELS-1:0] and a free-running WIDTH-bit counter, pwm_cnt, which ignores en.
  - pwm_out[c] is registered and equals (pwm_cnt < duty[c]); the period is 2^WIDTH cycles.
  - Reset values: pwm_cnt = 0, pwm_out = 0.
- Undefined: the port and the counter are absent; downstream drivers consume duty.

## Structure
- Package pwm_ramp_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the waypoint indexing function;
  - the elaboration-time q/r computation functions.
- Sub-module pwm_ramp_dda: one channel's duty/acc stepper with snap input. It is instantiated CHANNELS times under a shared controller (FSM and counters).

## Test plan
- Base configuration for scenarios 1–5: CHANNELS=2, WIDTH=8, STAGES=2, STAGE_CYCLES=12, UPDATE_DIV=4 (N=3). WP ch0 = 0,10,4. WP ch1 = 255,255,0. loop=0.
1. Reset then en=1 held -> ch0 duty 3,6,10 at updates 1..3, then 8,6,4. ch1 holds 255,255,255, then 170,85,0. stage_pulse at cycles 12 and 24. done=1 from cycle 25, holding 4 and 0.
2. loop=1, en held for 30 cycles -> after the second boundary, stage=0 and duty = {0,255}. The sequence repeats identically.
3. en low for 5 cycles mid stage 0, just after duty=3 -> duty holds 3. The next update lands exactly UPDATE_DIV cycles of en=1 after the previous one.
4. restart pulse during DONE, and again mid stage 1 with en=0 -> next cycle: stage=0, duty = {0,255}, done=0, FSM in RUN.
5. rst_n asserted asynchronously mid-update -> outputs return to reset values before the next clk edge. Operation is unaffected after release.
6. With PWM_RAMP_PWM_OUT_EN and duty ch0 = 64 -> pwm_out[0] is high for exactly 64 of every 256 cycles.
